// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side blocks.
package uart_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;

  localparam int UART_DBIT = 8;

  // Index width for n items; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set bit of req strictly after ptr, wrapping modulo N.
module rr_picker
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic [IW-1:0] cand;
    cand  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the UART TX FIFO write port among NREQ requesters.
// Optional idle-owner timeout release is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int DBIT      = UART_DBIT,
  parameter  int TO_CYCLES = 1024,
  parameter  int TO_W      = 11,
  localparam int IW        = clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               tx_full,
  output logic               wr_uart,
  output logic [DBIT-1:0]    w_data,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic               timeout_pulse
);

  if ((1 << TO_W) <= TO_CYCLES) begin : g_to_w_check
    $error("TO_W is too narrow to count to TO_CYCLES");
  end

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          own_valid, own_last, xfer, to_hit;

  rr_picker #(.N(NREQ), .IW(IW)) u_picker (
    .req   (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own_valid = req_valid[grant_q];
  assign own_last  = req_last[grant_q];
  assign xfer      = (state_q == ARB_BUSY) && own_valid && !tx_full;

  always_comb begin
    req_ready = '0;
    if (state_q == ARB_BUSY && !tx_full) req_ready[grant_q] = 1'b1;
  end

  assign wr_uart  = xfer;
  assign w_data   = xfer ? req_data[grant_q*DBIT +: DBIT] : '0;
  assign busy     = (state_q == ARB_BUSY);
  assign grant_id = grant_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Counts owner-idle cycles only; a full FIFO with valid held is not idleness.
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            pulse_q, pulse_d;

  assign to_hit = (state_q == ARB_BUSY) && !own_valid &&
                  (idle_cnt_q == TO_W'(TO_CYCLES - 1));

  always_comb begin
    idle_cnt_d = idle_cnt_q + 1'b1;
    if (state_q != ARB_BUSY || own_valid || to_hit) idle_cnt_d = '0;
    pulse_d = to_hit;
  end

  assign timeout_pulse = pulse_q;
`else
  assign to_hit        = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_BUSY;
          grant_d = pick_idx;
        end
      end
      ARB_BUSY: begin
        if ((xfer && own_last) || to_hit) begin
          state_d = ARB_IDLE;
          ptr_d   = grant_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      ptr_q      <= IW'(NREQ - 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
      idle_cnt_q <= '0;
      pulse_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
      pulse_q    <= pulse_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ = 4;
  localparam int DBIT = 8;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_CYCLES = 16;
`else
  localparam int TO_CYCLES = 1024;
`endif
  localparam int TO_W = 11;
  localparam int IW   = 2;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid, req_last, req_ready;
  logic [NREQ*DBIT-1:0] req_data;
  logic                 tx_full, wr_uart, busy, timeout_pulse;
  logic [DBIT-1:0]      w_data;
  logic [IW-1:0]        grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .TO_CYCLES(TO_CYCLES), .TO_W(TO_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .tx_full       (tx_full),
    .wr_uart       (wr_uart),
    .w_data        (w_data),
    .busy          (busy),
    .grant_id      (grant_id),
    .timeout_pulse (timeout_pulse)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int en_pct = 100;

  // Per-requester byte queues {last, data}
  logic [DBIT:0]   qmem [NREQ][64];
  int              qhd  [NREQ];
  int              qtl  [NREQ];
  logic            drv_v[NREQ];

  // Log of bytes written to the FIFO
  logic [DBIT-1:0] log_d[256];
  int              log_c[256];
  int              log_n = 0;

  task automatic push(input int r, input logic [DBIT-1:0] d, input logic l);
    if (qtl[r] < 64) begin
      qmem[r][qtl[r]] = {l, d};
      qtl[r]++;
    end
  endtask

  // Valid may rise whenever a byte is queued; once raised it holds until accepted.
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (!drv_v[i] && qhd[i] != qtl[i] && int'($urandom_range(99)) < en_pct) drv_v[i] = 1'b1;
      req_valid[i]              = drv_v[i];
      req_last[i]               = drv_v[i] ? qmem[i][qhd[i]][DBIT] : 1'b0;
      req_data[i*DBIT +: DBIT]  = drv_v[i] ? qmem[i][qhd[i]][DBIT-1:0] : DBIT'($urandom);
    end
  endtask

  task automatic advance();
    if (wr_uart && log_n < 256) begin
      log_d[log_n] = w_data;
      log_c[log_n] = cyc;
      log_n++;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        qhd[i]++;
        drv_v[i] = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    advance();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    tx_full   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    en_pct    = 100;
    log_n     = 0;
    for (int i = 0; i < NREQ; i++) begin
      qhd[i]   = 0;
      qtl[i]   = 0;
      drv_v[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) begin
      if (qhd[i] != qtl[i] || drv_v[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset_n   = 1'b0;
    tx_full   = 1'b0;
    req_valid = '1;
    req_last  = '1;
    req_data  = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== '0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    checks++; if (wr_uart !== 1'b0 || w_data !== '0) begin errors++; $display("FAIL reset_write wr=%b data=%h exp 0/00", wr_uart, w_data); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", timeout_pulse); end
  endtask

  task automatic test_single();
    do_reset();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    drive(); @(negedge clk);
    checks++; if (busy !== 1'b0 || wr_uart !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL single_idle busy=%b wr=%b rdy=%b exp 0/0/0000", busy, wr_uart, req_ready); end
    advance();
    drive(); @(negedge clk);
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin
      errors++; $display("FAIL single_grant busy=%b grant=%0d exp 1/0", busy, grant_id); end
    checks++; if (wr_uart !== 1'b1 || w_data !== 8'h41) begin
      errors++; $display("FAIL single_b0 wr=%b data=%h exp 1/41", wr_uart, w_data); end
    advance();
    drive(); @(negedge clk);
    checks++; if (wr_uart !== 1'b1 || w_data !== 8'h42 || req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_b1 wr=%b data=%h rdy=%b exp 1/42/0001", wr_uart, w_data, req_ready); end
    advance();
    drive(); @(negedge clk);
    checks++; if (busy !== 1'b0 || wr_uart !== 1'b0 || w_data !== '0) begin
      errors++; $display("FAIL single_done busy=%b wr=%b data=%h exp 0/0/00", busy, wr_uart, w_data); end
    advance();
  endtask

  task automatic test_round_robin();
    logic [DBIT-1:0] exp_d[5];
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();
    for (int i = 0; i < NREQ; i++) push(i, DBIT'(8'h10 + i), 1'b1);
    push(0, 8'h10, 1'b1);
    repeat (12) tick();
    checks++; if (log_n !== 5) begin errors++; $display("FAIL rr_count got=%0d exp=5", log_n); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (log_d[k] !== exp_d[k]) begin
        errors++; $display("FAIL rr_order[%0d] got=%h exp=%h", k, log_d[k], exp_d[k]); end
      if (k > 0) begin
        checks++; if (log_c[k] - log_c[k-1] !== 2) begin
          errors++; $display("FAIL rr_gap[%0d] got=%0d exp=2", k, log_c[k] - log_c[k-1]); end
      end
    end
  endtask

  task automatic test_packet_lock();
    logic [DBIT-1:0] exp_d[4];
    exp_d = '{8'h21, 8'h22, 8'h23, 8'h31};
    do_reset();
    push(2, 8'h21, 1'b0);
    push(2, 8'h22, 1'b0);
    push(2, 8'h23, 1'b1);
    for (int c = 0; c < 8; c++) begin
      if (c == 2) push(1, 8'h31, 1'b1);
      drive(); @(negedge clk);
      if (c <= 4) begin
        checks++; if (req_ready[1] !== 1'b0) begin
          errors++; $display("FAIL lock_ready1 cycle=%0d got=%b exp=0", c, req_ready[1]); end
      end
      advance();
    end
    checks++; if (log_n !== 4) begin errors++; $display("FAIL lock_count got=%0d exp=4", log_n); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (log_d[k] !== exp_d[k]) begin
        errors++; $display("FAIL lock_order[%0d] got=%h exp=%h", k, log_d[k], exp_d[k]); end
    end
    checks++; if (log_c[2] - log_c[0] !== 2) begin
      errors++; $display("FAIL lock_contig span=%0d exp=2", log_c[2] - log_c[0]); end
  endtask

  task automatic test_tx_full();
    do_reset();
    push(3, 8'h51, 1'b0);
    push(3, 8'h52, 1'b0);
    push(3, 8'h53, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tx_full = (c >= 2 && c <= 6);
      drive(); @(negedge clk);
      if (tx_full) begin
        checks++; if (wr_uart !== 1'b0 || req_ready !== '0) begin
          errors++; $display("FAIL full_stall cycle=%0d wr=%b rdy=%b exp 0/0000", c, wr_uart, req_ready); end
      end
      if (c == 7) begin
        checks++; if (wr_uart !== 1'b1 || w_data !== 8'h52) begin
          errors++; $display("FAIL full_resume wr=%b data=%h exp 1/52", wr_uart, w_data); end
      end
      advance();
    end
    checks++; if (log_n !== 3 || log_d[0] !== 8'h51 || log_d[1] !== 8'h52 || log_d[2] !== 8'h53) begin
      errors++; $display("FAIL full_stream n=%0d got=%h %h %h exp 3: 51 52 53", log_n, log_d[0], log_d[1], log_d[2]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    push(1, 8'h61, 1'b0);
    push(1, 8'h62, 1'b0);
    push(1, 8'h63, 1'b1);
    tick();
    tick();
    drive();
    #2;
    checks++; if (wr_uart !== 1'b1) begin errors++; $display("FAIL arst_pre wr=%b exp=1", wr_uart); end
    reset_n = 1'b0;
    #1;
    checks++; if (wr_uart !== 1'b0 || w_data !== '0 || req_ready !== '0 || busy !== 1'b0 || grant_id !== '0) begin
      errors++; $display("FAIL arst_zero wr=%b data=%h rdy=%b busy=%b grant=%0d exp all 0",
                         wr_uart, w_data, req_ready, busy, grant_id); end
    do_reset();
    for (int i = 0; i < NREQ; i++) push(i, DBIT'(8'h70 + i), 1'b1);
    tick();
    drive(); @(negedge clk);
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0 || w_data !== 8'h70) begin
      errors++; $display("FAIL arst_prio busy=%b grant=%0d data=%h exp 1/0/70", busy, grant_id, w_data); end
    advance();
  endtask

  task automatic test_hold();
    do_reset();
    push(0, 8'h81, 1'b0);
    push(2, 8'h91, 1'b1);
    tick();
    tick();
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int c = 2; c <= 19; c++) begin
      drive(); @(negedge clk);
      if (c <= 17) begin
        checks++; if (busy !== 1'b1 || grant_id !== 2'd0 || timeout_pulse !== 1'b0) begin
          errors++; $display("FAIL to_wait cycle=%0d busy=%b grant=%0d pulse=%b exp 1/0/0", c, busy, grant_id, timeout_pulse); end
      end else if (c == 18) begin
        checks++; if (timeout_pulse !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL to_pulse pulse=%b busy=%b exp 1/0", timeout_pulse, busy); end
      end else begin
        checks++; if (timeout_pulse !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd2 || w_data !== 8'h91) begin
          errors++; $display("FAIL to_next pulse=%b busy=%b grant=%0d data=%h exp 0/1/2/91",
                             timeout_pulse, busy, grant_id, w_data); end
      end
      advance();
    end
`else
    for (int c = 2; c < 42; c++) begin
      drive(); @(negedge clk);
      checks++; if (busy !== 1'b1 || grant_id !== 2'd0 || wr_uart !== 1'b0 || timeout_pulse !== 1'b0) begin
        errors++; $display("FAIL hold cycle=%0d busy=%b grant=%0d wr=%b pulse=%b exp 1/0/0/0",
                           c, busy, grant_id, wr_uart, timeout_pulse); end
      advance();
    end
    push(0, 8'h82, 1'b1);
    drive(); @(negedge clk);
    checks++; if (wr_uart !== 1'b1 || w_data !== 8'h82) begin
      errors++; $display("FAIL hold_resume wr=%b data=%h exp 1/82", wr_uart, w_data); end
    advance();
    tick();
    drive(); @(negedge clk);
    checks++; if (grant_id !== 2'd2 || w_data !== 8'h91) begin
      errors++; $display("FAIL hold_next grant=%0d data=%h exp 2/91", grant_id, w_data); end
    advance();
`endif
  endtask

  task automatic test_random();
    int              m_owner, m_ptr, m_gid, total, n, len, cand;
    logic            m_pulse, nx_pulse, ex_wr, found;
    logic [NREQ-1:0] ex_rdy;
    logic [DBIT-1:0] ex_wd;
`ifdef UART_TX_ARB_TIMEOUT_EN
    int              m_cnt;
    m_cnt = 0;
`endif
    do_reset();
    en_pct = 60;
    total  = 0;
    for (int r = 0; r < NREQ; r++) begin
      for (int p = 0; p < 3; p++) begin
        len = int'($urandom_range(4, 1));
        for (int b = 0; b < len; b++) push(r, DBIT'($urandom), b == len - 1);
        total += len;
      end
    end
    m_owner = -1;
    m_ptr   = NREQ - 1;
    m_gid   = 0;
    m_pulse = 1'b0;
    n       = 0;
    while (!all_empty() && n < 2000) begin
      tx_full = ($urandom_range(3) == 0);
      drive();
      @(negedge clk);
      ex_rdy = '0;
      ex_wr  = 1'b0;
      ex_wd  = '0;
      if (m_owner >= 0 && !tx_full) begin
        ex_rdy[m_owner] = 1'b1;
        if (req_valid[m_owner]) begin
          ex_wr = 1'b1;
          ex_wd = req_data[m_owner*DBIT +: DBIT];
        end
      end
      checks++; if (busy !== (m_owner >= 0) || grant_id !== IW'(m_gid)) begin
        errors++; $display("FAIL rnd_state cyc=%0d busy=%b grant=%0d exp %b/%0d", cyc, busy, grant_id, m_owner >= 0, m_gid); end
      checks++; if (req_ready !== ex_rdy) begin
        errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, ex_rdy); end
      checks++; if (wr_uart !== ex_wr || w_data !== ex_wd) begin
        errors++; $display("FAIL rnd_write cyc=%0d wr=%b data=%h exp %b/%h", cyc, wr_uart, w_data, ex_wr, ex_wd); end
      checks++; if (timeout_pulse !== m_pulse) begin
        errors++; $display("FAIL rnd_pulse cyc=%0d got=%b exp=%b", cyc, timeout_pulse, m_pulse); end
      nx_pulse = 1'b0;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          cand = (m_ptr + k) % NREQ;
          if (!found && req_valid[cand]) begin
            found   = 1'b1;
            m_owner = cand;
            m_gid   = cand;
          end
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        m_cnt = 0;
`endif
      end else if (ex_wr) begin
`ifdef UART_TX_ARB_TIMEOUT_EN
        m_cnt = 0;
`endif
        if (req_last[m_owner]) begin
          m_ptr   = m_owner;
          m_owner = -1;
        end
      end else if (!req_valid[m_owner]) begin
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (m_cnt == TO_CYCLES - 1) begin
          m_ptr    = m_owner;
          m_owner  = -1;
          nx_pulse = 1'b1;
          m_cnt    = 0;
        end else begin
          m_cnt++;
        end
`endif
      end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
        m_cnt = 0;
`endif
      end
      m_pulse = nx_pulse;
      advance();
      n++;
    end
    checks++; if (n >= 2000) begin errors++; $display("FAIL rnd_budget cycles=%0d exp<2000", n); end
    checks++; if (log_n !== total) begin errors++; $display("FAIL rnd_total got=%0d exp=%0d", log_n, total); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_tx_full();
    test_async_reset();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time=%0t exp finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
